instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
Owns the program counter and the IF/ID pipeline register of the MIPS core, directly upstream of the program memory ROM. Drives the byte address to the ROM and captures the returned instruction into IF/ID. Selects the next PC from sequential, branch, jump and jump-register sources, with stall, flush and a fetch-fault state for out-of-range or misaligned fetches.

Parameters:
DATA_WIDTH, 32, width of the PC, addresses and instructions.
RESET_PC, 32'h0040_0000, PC value after reset; this is the text segment base.
MEMORY_DEPTH, 2048, instruction words in the ROM; the legal fetch range is [RESET_PC, RESET_PC+4*MEMORY_DEPTH).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
Stall  in  1  hold the PC and IF/ID (from the hazard unit).
Flush  in  1  load a bubble into IF/ID.
Branch_Taken  in  1  branch resolved as taken.
Branch_Target  in  32  byte address of the branch destination.
Jump  in  1  J/JAL in ID.
Jump_Index  in  26  instr_index field of J/JAL.
JR  in  1  JR/JALR in ID.
JR_Target  in  32  register-sourced target.
Instruction  in  32  combinational ROM read data for PC_Address.
PC_Address  out  32  current PC, drives the ROM Address.
IF_ID_Instruction  out  32  latched instruction.
IF_ID_PC_Plus4  out  32  latched PC+4 of that instruction.
IF_ID_Valid  out  1  1 = IF/ID holds a real instruction.
Fetch_Fault  out  1  sticky fault flag.
Fault_PC  out  32  PC that caused the fault.

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_PC.
  - IF_ID_Instruction=0 (NOP), IF_ID_PC_Plus4=0, IF_ID_Valid=0.
  - Fetch_Fault=0, Fault_PC=0, FSM=RUN.
  - Applies immediately, mid-operation included.
- PC_Address = PC register, combinational. The ROM answers in the same cycle, so fetch latency is 1 clk: instruction at PC appears in IF/ID after the next rising edge.
- Jump target = {PCp4_ID[31:28], Jump_Index, 2'b00}, where PCp4_ID = IF_ID_PC_Plus4. All adds are 32-bit modulo; no carry out.
- Next-PC priority in RUN (highest first):
  1. Branch_Taken → Branch_Target.
  2. JR → JR_Target.
  3. Jump → jump target.
  4. Stall → PC held.
  5. Otherwise PC+4.
  - A redirect (items 1-3) overrides Stall.
- IF/ID update in RUN at each rising edge:
  - Redirect or Flush → bubble: Instruction=0, Valid=0, PC_Plus4 unchanged.
  - Else Stall → hold all IF/ID fields.
  - Else load Instruction, PC+4, Valid=1.
  - Flush has priority over Stall.
- Legality check on the current PC: illegal if PC[1:0]!=0, PC<RESET_PC, or PC>=RESET_PC+4*MEMORY_DEPTH.
- FSM states RUN and FAULT:
  - RUN→FAULT at the edge where the current PC is illegal and no redirect is asserted. That edge sets Fetch_Fault=1, latches Fault_PC=PC, loads a bubble into IF/ID and holds the PC.
  - If a redirect is asserted in that cycle, the redirect is taken and no fault is raised.
  - FAULT: PC frozen, IF/ID stays bubble, all inputs ignored. Exit only via reset.
- Wrap-around: the last legal word is RESET_PC+4*MEMORY_DEPTH-4. Sequential fetch past it yields an illegal PC and enters FAULT on the following edge; there is no wrap back to base.

Test Plan:
- Reset then free-run, ROM word i = 0x1000_0000+i → PC goes 0x00400000, 0x00400004, …; after the first edge IF_ID_Instruction=0x10000000, IF_ID_PC_Plus4=0x00400004, Valid=1; outputs at reset values while reset=0.
- Branch_Taken=1, Branch_Target=0x00400040 at PC=0x00400008 → next PC=0x00400040, IF/ID bubble (Valid=0) for one cycle, then the instruction at 0x00400040 with PC_Plus4=0x00400044.
- Jump=1, Jump_Index=0x0100010 with IF_ID_PC_Plus4=0x00400010 → PC=0x00400040. Assert Jump and Branch_Taken (target 0x00400080) together → PC=0x00400080.
- Stall=1 for 3 cycles at PC=0x0040000C → PC and IF/ID unchanged for 3 edges. Stall+Flush together → PC held, Valid=0.
- JR=1, JR_Target=0x00400006 → PC=0x00400006; next edge Fetch_Fault=1, Fault_PC=0x00400006, Valid=0. PC stays frozen for 10 cycles despite input toggling.
- Reset asserted mid-run and while in FAULT → async return to PC=0x00400000 with Fault cleared. Sequential run to 0x00401FFC → PC reaches 0x00402000, then fault with Fault_PC=0x00402000.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: owns the PC and the IF/ID register. It selects the
// next PC from its redirect sources and stops in a sticky FAULT state on an illegal fetch.
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
    parameter int                    MEMORY_DEPTH = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  Branch_Taken,
    input  logic [DATA_WIDTH-1:0] Branch_Target,
    input  logic                  Jump,
    input  logic [25:0]           Jump_Index,
    input  logic                  JR,
    input  logic [DATA_WIDTH-1:0] JR_Target,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PC_Address,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction,
    output logic [DATA_WIDTH-1:0] IF_ID_PC_Plus4,
    output logic                  IF_ID_Valid,
    output logic                  Fetch_Fault,
    output logic [DATA_WIDTH-1:0] Fault_PC,
    output logic                  fsm_state_dbg
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    localparam logic [DATA_WIDTH-1:0] PC_LIMIT = RESET_PC + DATA_WIDTH'(4 * MEMORY_DEPTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
    logic                  ifid_valid_q, ifid_valid_d;
    logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] jump_target;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  redirect;
    logic                  pc_legal;

    assign pc_plus4    = pc_q + DATA_WIDTH'(4);
    assign jump_target = {ifid_pc4_q[DATA_WIDTH-1:DATA_WIDTH-4], Jump_Index, 2'b00};
    assign redirect    = Branch_Taken | JR | Jump;
    assign pc_legal    = (pc_q[1:0] == 2'b00) && (pc_q >= RESET_PC) && (pc_q < PC_LIMIT);

    always_comb begin
        redirect_target = jump_target;
        if (Branch_Taken) begin
            redirect_target = Branch_Target;
        end else if (JR) begin
            redirect_target = JR_Target;
        end
    end

    // A redirect beats both Stall and the legality check, so a bad PC can be escaped.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fault_pc_d   = fault_pc_q;
        unique case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    pc_d         = redirect_target;
                    ifid_instr_d = '0;
                    ifid_valid_d = 1'b0;
                end else if (!pc_legal) begin
                    state_d      = ST_FAULT;
                    fault_pc_d   = pc_q;
                    ifid_instr_d = '0;
                    ifid_valid_d = 1'b0;
                end else if (Flush) begin
                    ifid_instr_d = '0;
                    ifid_valid_d = 1'b0;
                    if (!Stall) begin
                        pc_d = pc_plus4;
                    end
                end else if (!Stall) begin
                    pc_d         = pc_plus4;
                    ifid_instr_d = Instruction;
                    ifid_pc4_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                end
            end
            ST_FAULT: begin
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            fault_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    assign PC_Address        = pc_q;
    assign IF_ID_Instruction = ifid_instr_q;
    assign IF_ID_PC_Plus4    = ifid_pc4_q;
    assign IF_ID_Valid       = ifid_valid_q;
    assign Fetch_Fault       = (state_q == ST_FAULT);
    assign Fault_PC          = fault_pc_q;
    assign fsm_state_dbg     = state_q;

endmodule
